// File: rtl/dp3_sched.sv
// ---------------------------------------------------------------------------
// dp3_sched -- issue scheduler for a 3D dynamic-programming cell datapath.
//
// Walks every cell (i,j,k) of a (len_i+1) x (len_j+1) x (len_k+1) matrix,
// i outermost and k innermost, and offers each cell to a fixed-latency
// datapath over a valid/ready handshake. After each transfer the next cell
// is held back for LAT-1 cycles so that the k-1 neighbour's result is
// written back before it is needed. A LAT-deep shift register produces
// the write-back strobe for every transferred cell.
//
// Parameters:
//   LAT  datapath latency from issue to write-back, 1..7
//   W    coordinate / length width
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    begin a fill (accepted only when idle)
//   abort                    terminate the current fill on the next edge
//   len_i, len_j, len_k      sequence lengths, latched on accepted start
//   cell_valid, cell_ready   cell handshake towards the datapath
//   ci, cj, ck               coordinates of the offered cell
//   border                   offered cell lies on a gap-init plane
//   wb_valid                 write-back strobe, LAT cycles after transfer
//   busy                     fill in progress (RUN or DRAIN)
//   done                     one-cycle pulse with the final write-back
//   cell_count               transfers in the current or last fill
// ---------------------------------------------------------------------------
module dp3_sched #(
   parameter int LAT = 3,
   parameter int W   = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           abort,
   input  logic [W-1:0]   len_i,
   input  logic [W-1:0]   len_j,
   input  logic [W-1:0]   len_k,
   output logic           cell_valid,
   input  logic           cell_ready,
   output logic [W-1:0]   ci,
   output logic [W-1:0]   cj,
   output logic [W-1:0]   ck,
   output logic           border,
   output logic           wb_valid,
   output logic           busy,
   output logic           done,
   output logic [3*W-1:0] cell_count
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   // number of idle cycles inserted after each transfer
   localparam logic [2:0]     GAP     = 3'(LAT - 1);
   localparam logic [3*W-1:0] CNT_ONE = (3*W)'(1);

   state_t         state_reg, state_next;
   logic [W-1:0]   li_reg, lj_reg, lk_reg;
   logic [W-1:0]   ci_reg, cj_reg, ck_reg;
   logic [3*W-1:0] count_reg;
   logic [2:0]     gap_reg;
   logic [LAT-1:0] wb_sr_reg;
   logic [LAT-1:0] wb_sr_next;
   logic           xfer;
   logic           last_cell;
   logic           accept;

   assign cell_valid = (state_reg == RUN) && (gap_reg == 3'd0);
   assign xfer       = cell_valid & cell_ready;
   assign last_cell  = (ci_reg == li_reg) && (cj_reg == lj_reg) && (ck_reg == lk_reg);

   assign ci         = ci_reg;
   assign cj         = cj_reg;
   assign ck         = ck_reg;
   assign border     = (ci_reg == '0) || (cj_reg == '0) || (ck_reg == '0);
   assign cell_count = count_reg;
   assign wb_valid   = wb_sr_reg[LAT-1];

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && !abort) begin
               state_next = RUN;
               accept     = 1'b1;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (xfer && last_cell) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            // Transfers are spaced at least LAT cycles apart, so the only
            // result still in flight here belongs to the final cell.
            if (wb_valid) begin
               state_next = IDLE;
               done       = !abort;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (abort) begin
         state_next = IDLE;
      end
   end

   // ---------------------------------------------------------------------
   // Write-back delay line: bit 0 captures the transfer, each later stage
   // copies its predecessor.
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < LAT; gi++) begin : g_wb
         if (gi == 0) begin : g_head
            assign wb_sr_next[gi] = xfer;
         end else begin : g_tail
            assign wb_sr_next[gi] = wb_sr_reg[gi-1];
         end
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Datapath: lengths, coordinates, hazard gap, transfer count.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         li_reg    <= '0;
         lj_reg    <= '0;
         lk_reg    <= '0;
         ci_reg    <= '0;
         cj_reg    <= '0;
         ck_reg    <= '0;
         count_reg <= '0;
         gap_reg   <= 3'd0;
         wb_sr_reg <= '0;
      end else begin
         wb_sr_reg <= abort ? '0 : wb_sr_next;
         if (abort) begin
            // coordinates and count are left as they were
            gap_reg <= 3'd0;
         end else if (accept) begin
            li_reg    <= len_i;
            lj_reg    <= len_j;
            lk_reg    <= len_k;
            ci_reg    <= '0;
            cj_reg    <= '0;
            ck_reg    <= '0;
            count_reg <= '0;
            gap_reg   <= 3'd0;
         end else if (xfer) begin
            count_reg <= count_reg + CNT_ONE;
            gap_reg   <= GAP;
            // the final cell keeps its coordinates; the fill is over
            if (!last_cell) begin
               if (ck_reg != lk_reg) begin
                  ck_reg <= ck_reg + W'(1);
               end else begin
                  ck_reg <= '0;
                  if (cj_reg != lj_reg) begin
                     cj_reg <= cj_reg + W'(1);
                  end else begin
                     cj_reg <= '0;
                     ci_reg <= ci_reg + W'(1);
                  end
               end
            end
         end else if (gap_reg != 3'd0) begin
            gap_reg <= gap_reg - 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_dp3_sched.sv
// ---------------------------------------------------------------------------
// tb_dp3_sched -- self-checking bench for dp3_sched (LAT=3, W=4).
//
// For each fill the reference model enumerates the expected cell order with
// plain nested loops, then follows the handshake cycle by cycle: a cell is
// due once LAT cycles have passed since the previous transfer, every
// transfer schedules a write-back LAT cycles later, and the fill ends with
// the write-back of the last cell.
// ---------------------------------------------------------------------------
module tb_dp3_sched;

   localparam int LAT = 3;
   localparam int W   = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           abort = 1'b0;
   logic           cell_ready = 1'b0;
   logic [W-1:0]   len_i = '0;
   logic [W-1:0]   len_j = '0;
   logic [W-1:0]   len_k = '0;
   logic           cell_valid;
   logic [W-1:0]   ci, cj, ck;
   logic           border;
   logic           wb_valid;
   logic           busy;
   logic           done;
   logic [3*W-1:0] cell_count;

   int n_tests = 0;
   int n_fail  = 0;

   dp3_sched #(.LAT(LAT), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .len_i      (len_i),
      .len_j      (len_j),
      .len_k      (len_k),
      .cell_valid (cell_valid),
      .cell_ready (cell_ready),
      .ci         (ci),
      .cj         (cj),
      .ck         (ck),
      .border     (border),
      .wb_valid   (wb_valid),
      .busy       (busy),
      .done       (done),
      .cell_count (cell_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_valid"}, 32'(cell_valid), 32'd0);
      chk({tag, "_wb"},    32'(wb_valid),   32'd0);
      chk({tag, "_busy"},  32'(busy),       32'd0);
      chk({tag, "_done"},  32'(done),       32'd0);
      chk({tag, "_ci"},    32'(ci),         32'd0);
      chk({tag, "_cj"},    32'(cj),         32'd0);
      chk({tag, "_ck"},    32'(ck),         32'd0);
      chk({tag, "_border"},32'(border),     32'd1);
      chk({tag, "_count"}, 32'(cell_count), 32'd0);
   endtask

   // a,b,c        : lengths
   // rdy_pct      : probability (percent) of cell_ready each cycle
   // abort_at     : abort right after this many transfers (-1 = never)
   // poke         : raise start at random while busy
   // rst_drain    : pulse rst once the fill has reached DRAIN
   task automatic run_fill(input int a, input int b, input int c, input int rdy_pct,
                           input int abort_at, input bit poke, input bit rst_drain);
      logic [3*W-1:0] cq[$];
      logic [3*W-1:0] e;
      int             wbq[$];
      int             exp_cnt    = 0;
      int             next_offer = 0;
      int             now        = 0;
      int             guard      = 0;
      bit             mbusy;
      bit             ev, ew, ed, ab, tx;
      bit             exp_border;

      for (int i = 0; i <= a; i++)
         for (int j = 0; j <= b; j++)
            for (int k = 0; k <= c; k++)
               cq.push_back({W'(i), W'(j), W'(k)});

      // issue the start while idle; cell_ready toggling here must be ignored
      @(negedge clk);
      rst        = 1'b0;
      abort      = 1'b0;
      len_i      = W'(a);
      len_j      = W'(b);
      len_k      = W'(c);
      start      = 1'b1;
      cell_ready = 1'($urandom_range(0, 1));
      #1;
      chk("idle_busy",  32'(busy),       32'd0);
      chk("idle_valid", 32'(cell_valid), 32'd0);
      mbusy = 1'b1;

      while (mbusy) begin
         @(negedge clk);
         ab         = (abort_at >= 0) && (exp_cnt == abort_at);
         abort      = ab;
         start      = poke && ($urandom_range(0, 3) == 0);
         len_i      = W'($urandom);
         len_j      = W'($urandom);
         len_k      = W'($urandom);
         cell_ready = ($urandom_range(0, 99) < rdy_pct);
         #1;
         ev = (cq.size() > 0) && (now >= next_offer);
         ew = (wbq.size() > 0) && (wbq[0] == now);
         ed = ew && (cq.size() == 0) && (wbq.size() == 1) && !ab;
         chk("cell_valid", 32'(cell_valid), 32'(ev));
         chk("wb_valid",   32'(wb_valid),   32'(ew));
         chk("done",       32'(done),       32'(ed));
         chk("busy",       32'(busy),       32'd1);
         if (ev) begin
            e          = cq[0];
            exp_border = (e[3*W-1:2*W] == '0) || (e[2*W-1:W] == '0) || (e[W-1:0] == '0);
            chk("ci",     32'(ci),     32'(e[3*W-1:2*W]));
            chk("cj",     32'(cj),     32'(e[2*W-1:W]));
            chk("ck",     32'(ck),     32'(e[W-1:0]));
            chk("border", 32'(border), 32'(exp_border));
         end
         tx = ev && cell_ready && !ab;
         if (ab) begin
            cq.delete();
            wbq.delete();
            mbusy = 1'b0;
         end else if (rst_drain && (cq.size() == 0) && (wbq.size() > 0) && !ew) begin
            // DUT is in DRAIN: reset must clear everything without a clock
            #1;
            rst = 1'b1;
            #1;
            chk_reset_values("rst_drain");
            cq.delete();
            wbq.delete();
            exp_cnt = 0;
            mbusy   = 1'b0;
         end else begin
            if (ew) void'(wbq.pop_front());
            if (tx) begin
               void'(cq.pop_front());
               wbq.push_back(now + LAT);
               next_offer = now + LAT;
               exp_cnt++;
            end
            if (ed) mbusy = 1'b0;
         end
         now++;
         guard++;
         if (guard > 2000) begin
            chk("timeout", 32'd1, 32'd0);
            mbusy = 1'b0;
         end
      end

      // back in IDLE: nothing may be issued or written back, count holds
      for (int n = 0; n < LAT + 2; n++) begin
         @(negedge clk);
         rst        = 1'b0;
         abort      = 1'b0;
         start      = 1'b0;
         cell_ready = 1'($urandom_range(0, 1));
         #1;
         chk("post_valid", 32'(cell_valid), 32'd0);
         chk("post_wb",    32'(wb_valid),   32'd0);
         chk("post_busy",  32'(busy),       32'd0);
         chk("post_done",  32'(done),       32'd0);
      end
      chk("cell_count", 32'(cell_count), 32'(exp_cnt));
      $display("[TB] fill %0d/%0d/%0d ready=%0d%% abort_at=%0d: %0d transfers expected, count=%0d",
               a, b, c, rdy_pct, abort_at, exp_cnt, cell_count);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_values("reset");
      @(negedge clk);
      rst = 1'b0;

      run_fill(1, 1, 1, 100, -1, 1'b0, 1'b0);   // 8 cells, back-to-back ready
      run_fill(0, 0, 0, 100, -1, 1'b0, 1'b0);   // single border cell
      run_fill(2, 0, 3, 50,  -1, 1'b0, 1'b0);   // random stalls
      run_fill(2, 2, 2, 100,  5, 1'b0, 1'b0);   // abort after 5th transfer
      run_fill(1, 1, 1, 100, -1, 1'b0, 1'b1);   // reset during DRAIN
      run_fill(1, 2, 1, 70,  -1, 1'b1, 1'b0);   // start pokes while busy
      for (int t = 0; t < 4; t++) begin
         run_fill($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                  $urandom_range(40, 100), -1, 1'b1, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dp3_sched.md
DP3_SCHED -- requirements
Module: dp3_sched

Interface
REQ-001 Parameter LAT, default 3, meaning fixed cycle latency of the 3D cell datapath from issue to result write-back (legal 1..7).
REQ-002 Parameter W, default 4, meaning coordinate and length width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a matrix fill; honored only in IDLE.
REQ-006 abort  input  1  terminate the current fill.
REQ-007 len_i, len_j, len_k  input  W each  sequence lengths; sampled on accepted start.
REQ-008 cell_valid  output  1  cell coordinates valid for the datapath.
REQ-009 cell_ready  input  1  datapath accepts the cell; transfer = cell_valid & cell_ready.
REQ-010 ci, cj, ck  output  W each  coordinates of the offered cell.
REQ-011 border  output  1  high when any of ci, cj, ck is 0 (gap-init cell).
REQ-012 wb_valid  output  1  result write-back strobe for a transferred cell.
REQ-013 busy  output  1  high in RUN or DRAIN.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 cell_count  output  3*W  cells transferred in the current or last fill.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DRAIN; IDLE->RUN on start, RUN->DRAIN on the transfer of the last cell, DRAIN->IDLE when the last wb_valid is emitted.
REQ-017 On accepted start the block SHALL latch all lengths, zero ci/cj/ck and cell_count, and assert cell_valid on the next cycle.
REQ-018 The scan SHALL visit every (i,j,k) with 0<=i<=len_i, 0<=j<=len_j, 0<=k<=len_k, i outermost, k innermost, ascending, yielding (len_i+1)(len_j+1)(len_k+1) transfers.
REQ-019 cell_valid with ci/cj/ck SHALL stay stable until transfer; coordinates advance only on transfer.
REQ-020 After each transfer cell_valid SHALL be low for exactly LAT-1 cycles before the next cell is offered (k-1 dependency hazard); with LAT=1 back-to-back transfers are allowed.
REQ-021 wb_valid SHALL assert exactly LAT cycles after each transfer, via a LAT-deep shift register.
REQ-022 Coordinate wrap: k reaching len_k SHALL reset k to 0 and increment j; j reaching len_j likewise increments i; no counter exceeds its latched length.
REQ-023 cell_count SHALL increment by 1 per transfer and hold its final value in IDLE until the next accepted start.
REQ-024 done SHALL pulse in the same cycle as the final wb_valid.
REQ-025 start while busy SHALL be ignored with no effect on state or outputs.
REQ-026 All lengths 0 SHALL produce one transfer of (0,0,0) with border=1.
REQ-027 abort (any state) SHALL force IDLE on the next edge: cell_valid, wb_valid, busy low, shift register cleared, no done pulse, cell_count held; abort wins over simultaneous start.
REQ-028 cell_ready while cell_valid is low SHALL be ignored.

Reset
REQ-029 rst asserted SHALL immediately force IDLE, cell_valid=0, wb_valid=0, busy=0, done=0, ci=cj=ck=0, border=1, cell_count=0, shift register cleared.
REQ-030 rst asserted mid-fill SHALL discard the fill; after release the block waits for a new start.

Verification
REQ-031 LAT=3, lengths 1/1/1, cell_ready tied 1 -> 8 transfers in order (0,0,0)..(1,1,1), issue spacing 3 cycles, border low only at (1,1,1), done with 8th wb_valid, cell_count=8.
REQ-032 Lengths 0/0/0 -> single transfer (0,0,0), border=1, done 3 cycles later.
REQ-033 Lengths 2/0/3, cell_ready toggled randomly -> coordinates stable while stalled, 12 transfers, wb_valid count 12, each exactly 3 cycles after its transfer.
REQ-034 Abort after 5th transfer of a 2/2/2 fill -> IDLE next cycle, no further wb_valid, no done, cell_count=5.
REQ-035 rst pulse during DRAIN -> all outputs at reset values immediately; start issued during busy in a separate run -> ignored, fill completes normally.
